// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the fetch PC, issues word reads to instruction memory with at most one
// request outstanding, and buffers returned words in a small FIFO that feeds
// decode through a valid/ready handshake. A redirect from the control unit
// flushes the FIFO and drops any response that is still in flight.
//
// Optional feature: FETCH_BYPASS_EN. When defined, a response that arrives
// while the FIFO is empty is presented to decode in the same cycle. Leaving it
// undefined keeps every word registered in the FIFO (no combinational path from
// imem_rdata/imem_rvalid to the outputs).
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     read request (accepted in every cycle it is high)
//   imem_addr    word-aligned request address
//   imem_rdata   returned instruction word
//   imem_rvalid  response strobe
//   pc_src       redirect request
//   pc_target    redirect address (bits [1:0] ignored)
//   instr        head instruction, NOP when invalid
//   pc           address of instr, 0 when invalid
//   pc_plus4     pc + 4 (wraps)
//   instr_valid  head entry present
//   instr_ready  decode consumes the head when high with instr_valid
//
// State | meaning
// ------+-------------------------------------------------------------
// RUN   | no request outstanding; issue when a FIFO slot is free
// WAIT  | one request outstanding; its response is pushed on arrival
// DISCARD | request outstanding but a redirect happened; drop its response

module fetch_unit #(
   parameter int              WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             imem_rvalid,
   input  logic             pc_src,
   input  logic [WIDTH-1:0] pc_target,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             instr_valid,
   input  logic             instr_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
   localparam logic [WIDTH-1:0] NOP        = WIDTH'(32'h0000_0013);
   localparam logic [WIDTH-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] fpc;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] fifo_instr [DEPTH];
   logic [WIDTH-1:0] fifo_pc    [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;

   logic head_valid;
   logic issue;
   logic rsp;
   logic push;
   logic pop;
   logic bypass;

   assign head_valid = (count != '0);
   // Reset gates the request so it drops as soon as rst asserts, not at the next edge.
   assign issue = rst && (state == S_RUN) && (count < CW'(DEPTH)) && !pc_src;
   assign rsp   = (state == S_WAIT) && imem_rvalid;
   assign pop   = head_valid && instr_ready;

`ifdef FETCH_BYPASS_EN
   assign bypass = rsp && !head_valid;
   // A bypassed word that decode takes immediately never needs a FIFO slot.
   assign push   = rsp && !pc_src && !(bypass && instr_ready);
`else
   assign bypass = 1'b0;
   assign push   = rsp && !pc_src;
`endif

   assign imem_req  = issue;
   assign imem_addr = fpc;

   always_comb begin
      instr_valid = 1'b0;
      instr       = NOP;
      pc          = '0;
      if (head_valid) begin
         instr_valid = 1'b1;
         instr       = fifo_instr[rd_ptr];
         pc          = fifo_pc[rd_ptr];
      end else if (bypass) begin
         instr_valid = 1'b1;
         instr       = imem_rdata;
         pc          = req_addr;
      end
   end

   assign pc_plus4 = pc + WIDTH'(4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RUN;
         fpc      <= PC_INIT;
         req_addr <= PC_INIT;
      end else begin
         case (state)
            S_RUN:     if (issue) state <= S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) state <= S_RUN;
               else if (pc_src) state <= S_DISCARD;
            end
            S_DISCARD: if (imem_rvalid) state <= S_RUN;
            default:   state <= S_RUN;
         endcase

         if (pc_src) begin
            fpc <= pc_target & ALIGN_MASK;
         end else if (issue) begin
            fpc      <= fpc + WIDTH'(4);
            req_addr <= fpc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (pc_src) begin
         // Flush; a same-cycle pop has already completed at decode.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= req_addr;
      end
   end

endmodule
